// File: rtl/wb_cmd_master.sv
// Wishbone B4 pipelined single-transfer initiator: turns a valid/ready command
// stream into one bus cycle at a time and returns data/status on a response stream.
module wb_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_stall_i
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          bus_resp;
  logic          done;
  logic          expire;

  // A response only counts in REQ once the request itself is being taken.
  always_comb begin
    bus_resp = wb_ack_i | wb_err_i;
    done     = bus_resp && ((state == WAIT) || (state == REQ && !wb_stall_i));
    expire   = TIMEOUT_EN && (cnt == CNT_LAST);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= '0;
      wb_stb_o    <= 1'b0;
      wb_cyc_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wb_adr_o  <= cmd_addr;
            wb_dat_o  <= cmd_wdata;
            wb_we_o   <= cmd_we;
            wb_sel_o  <= cmd_sel;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            cmd_ready <= 1'b0;
            cnt       <= '0;
            state     <= REQ;
          end
        end
        REQ, WAIT: begin
          if (TIMEOUT_EN && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
          if (done || expire) begin
            // Bus signals return to idle levels whenever the cycle ends.
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= '0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            rsp_valid   <= 1'b1;
            rsp_err     <= done && wb_err_i;
            rsp_timeout <= !done;
            rsp_rdata   <= (done && !wb_err_i && !wb_we_o) ? wb_dat_i : '0;
            state       <= RESP;
          end else if (state == REQ && !wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
